step_playback: RTL and testbench
================================

// Module: step_playback
// PURPOSE
//  Playback engine downstream of the sequence editor. Walks the 8-step pattern (seq_smpl_1..8) at a
//  programmable tempo. At each step start it issues that step's 4-bit sample mask to the audio mixer
//  over a valid/ready handshake. Also drives the current step index to the step LEDs/display.
// PARAMETERS
//  BASE_DIV  100_000  clock cycles per tempo unit; step period = (tempo+1)*BASE_DIV cycles
//  DIV_W     32       divider counter width; must hold 256*BASE_DIV-1
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  mode         in   2   2'b01 = play mode; any other value forces STOP
//  start_stop   in   1   1-cycle pulse: STOP->RUN, RUN->PAUSE, PAUSE->RUN
//  stop         in   1   1-cycle pulse: any state -> STOP, step rewinds to 0
//  tempo        in   8   step period select, sampled at each step start
//  seq_smpl_1..8 in  4   per-step sample masks from the sequence editor (bit n = sample n)
//  trig_mask    out  4   sample mask of the pending trigger
//  trig_valid   out  1   trigger pending; held until accepted
//  trig_ready   in   1   mixer accepts trigger when trig_valid & trig_ready
//  overrun      out  1   sticky: a pending trigger was replaced before acceptance
//  step_idx     out  3   current step (0..7)
//  step_tick    out  1   1-cycle pulse at every step start, including empty steps
//  running      out  1   high in RUN
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=STOP, step_idx=0, divider=0, trig_mask=0, trig_valid=0
//   - overrun=0, step_tick=0, running=0
//  FSM states: STOP, RUN, PAUSE.
//   - Priority each cycle: mode!=01 or stop -> STOP (outranks start_stop). Then start_stop.
//   - STOP: step_idx=0, divider=0. start_stop & mode==01 -> RUN, with a step start on the next cycle.
//   - RUN: divider counts 0..period-1. On divider==period-1: divider->0, step_idx+1 (7 wraps to 0),
//     step start. start_stop -> PAUSE.
//   - PAUSE: divider and step_idx frozen. start_stop -> RUN, resuming the divider where it stopped.
//     Resume is not a step start.
//  Step start (registered, so visible one cycle after the triggering edge/pulse):
//   - step_tick=1 for exactly 1 cycle.
//   - period latched = (tempo+1)*BASE_DIV. Tempo changes mid-step take effect at the next step.
//   - mask = seq_smpl_<step_idx+1> sampled that cycle. Editor writes take effect on the next visit.
//   - If mask!=0: trig_mask<=mask, trig_valid<=1.
//   - If trig_valid was still high and not accepted that cycle: the old trigger is replaced and
//     overrun<=1.
//   - If mask==0: an existing pending trigger is left untouched.
//  Handshake:
//   - trig_mask must not change while trig_valid=1, except by replacement at a step start.
//   - trig_valid & trig_ready -> trig_valid<=0 next cycle. If a step start coincides with acceptance,
//     the new trigger is loaded (valid stays 1) and overrun is not set.
//  Leaving RUN/PAUSE to STOP: pending trigger dropped (trig_valid<=0), step_idx<=0.
//  overrun clears only on reset or stop pulse. running = (state==RUN).
//  Arithmetic: period product computed at DIV_W bits, unsigned; no saturation needed at defaults.
// TESTING (BASE_DIV=4, tempo=1 -> period 8 cycles unless stated)
//  1. Pattern {s1=0001, s2=0010, s3=0, ... s8=1000}, mode=01, start_stop pulse, trig_ready=1 ->
//     step_tick every 8 cycles; step_idx 0,1,2..7,0.
//     trig_valid pulses with masks 0001, 0010, (none), ..., 1000, then 0001 again.
//  2. trig_ready=0 for 20 cycles after start with s1=0001, s2=0100 ->
//     trig_mask holds 0001 until step 1, then becomes 0100 and overrun=1.
//     stop pulse -> overrun=0, trig_valid=0.
//  3. In RUN at step 3, divider=5: start_stop -> frozen 10 cycles. start_stop ->
//     step 4 begins exactly 3 cycles later; no step_tick on resume.
//  4. tempo 1->3 mid-step 2 -> step 2 still lasts 8 cycles; step 3 lasts 16 cycles.
//  5. Same-cycle start_stop+stop in RUN -> STOP, step_idx=0.
//     mode->00 while RUN -> STOP next cycle, trig_valid=0.
//  6. rst_n low mid-step with trig_valid=1 -> all outputs 0 immediately, without a clock edge.
//     After release, start_stop -> step 0 trigger fires.

Source files
------------

// File: rtl/step_playback_if.sv
// Trigger handshake between the playback engine and the audio mixer.
// Master drives the mask/valid pair, slave answers with ready.
interface step_playback_if;
  logic [3:0] trig_mask;
  logic       trig_valid;
  logic       trig_ready;

  modport master (
    output trig_mask,
    output trig_valid,
    input  trig_ready
  );

  modport slave (
    input  trig_mask,
    input  trig_valid,
    output trig_ready
  );
endinterface

// File: rtl/step_playback.sv
// 8-step pattern playback: walks the steps at a programmable tempo and
// hands each non-empty step's sample mask to the mixer.
module step_playback #(
  parameter int BASE_DIV = 100_000,
  parameter int DIV_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        start_stop,
  input  logic        stop,
  input  logic [7:0]  tempo,
  input  logic [3:0]  seq_smpl_1,
  input  logic [3:0]  seq_smpl_2,
  input  logic [3:0]  seq_smpl_3,
  input  logic [3:0]  seq_smpl_4,
  input  logic [3:0]  seq_smpl_5,
  input  logic [3:0]  seq_smpl_6,
  input  logic [3:0]  seq_smpl_7,
  input  logic [3:0]  seq_smpl_8,
  step_playback_if.master trig,
  output logic        overrun,
  output logic [2:0]  step_idx,
  output logic        step_tick,
  output logic        running
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_DIV);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [2:0]       step_q, step_d;
  logic             tick_q, tick_d;
  logic [3:0]       mask_q, mask_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             go_stop;
  logic             start;
  logic             run_now;
  logic             wrap;
  logic             step_start;
  logic [2:0]       idx_nxt;
  logic [3:0]       mask_sel;
  logic [8:0]       tempo_p1;
  logic [DIV_W-1:0] prod;
  logic             accept;

  // Stop and mode loss outrank the start/stop toggle.
  assign go_stop = stop | (mode != 2'b01);
  assign start   = start_stop & ~go_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      go_stop: state_d = ST_STOP;
      start: begin
        if (state_q == ST_RUN) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    run_now    = (state_q == ST_RUN);
    wrap       = run_now &&
                 (div_q == period_q - DIV_W'(1));
    step_start = 1'b0;
    idx_nxt    = step_q + 3'd1;
    unique case (state_q)
      ST_STOP: begin
        step_start = start;
        idx_nxt    = 3'd0;
      end
      ST_RUN: begin
        step_start = wrap & ~go_stop & ~start;
      end
      default: begin
        step_start = 1'b0;
      end
    endcase
  end

  always_comb begin
    mask_sel = 4'd0;
    unique case (idx_nxt)
      3'd0: mask_sel = seq_smpl_1;
      3'd1: mask_sel = seq_smpl_2;
      3'd2: mask_sel = seq_smpl_3;
      3'd3: mask_sel = seq_smpl_4;
      3'd4: mask_sel = seq_smpl_5;
      3'd5: mask_sel = seq_smpl_6;
      3'd6: mask_sel = seq_smpl_7;
      3'd7: mask_sel = seq_smpl_8;
      default: mask_sel = 4'd0;
    endcase
  end

  assign tempo_p1 = {1'b0, tempo} + 9'd1;
  assign prod     = DIV_W'(tempo_p1) * BASE;
  assign accept   = valid_q & trig.trig_ready;

  always_comb begin
    div_d    = div_q;
    period_d = period_q;
    step_d   = step_q;
    tick_d   = step_start;
    if (state_d == ST_STOP || step_start) begin
      div_d = '0;
    end else if (run_now && state_d == ST_RUN) begin
      div_d = div_q + DIV_W'(1);
    end
    if (step_start) begin
      period_d = prod;
    end
    if (go_stop) begin
      step_d = 3'd0;
    end else if (step_start) begin
      step_d = idx_nxt;
    end
  end

  // An empty step leaves any pending trigger alone.
  always_comb begin
    mask_d  = mask_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (go_stop) begin
      valid_d = 1'b0;
    end else if (step_start && mask_sel != 4'd0) begin
      mask_d  = mask_sel;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (stop) begin
      ovr_d = 1'b0;
    end else if (step_start && mask_sel != 4'd0 &&
                 valid_q && !trig.trig_ready) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      period_q <= '0;
      step_q   <= 3'd0;
      tick_q   <= 1'b0;
      mask_q   <= 4'd0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      period_q <= period_d;
      step_q   <= step_d;
      tick_q   <= tick_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign trig.trig_mask  = mask_q;
  assign trig.trig_valid = valid_q;
  assign overrun         = ovr_q;
  assign step_idx        = step_q;
  assign step_tick       = tick_q;
  assign running         = run_now;

endmodule

// File: tb/tb_step_playback.sv
// Bench for step_playback: directed scenarios then random play,
// all outputs compared every cycle against a step-level reference model.
module tb_step_playback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       start_stop;
  logic       stop;
  logic [7:0] tempo;
  logic [3:0] pat [8];
  logic       overrun;
  logic [2:0] step_idx;
  logic       step_tick;
  logic       running;

  step_playback_if trig_if ();

  always #5 clk = ~clk;

  step_playback #(
    .BASE_DIV (4),
    .DIV_W    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .start_stop (start_stop),
    .stop       (stop),
    .tempo      (tempo),
    .seq_smpl_1 (pat[0]),
    .seq_smpl_2 (pat[1]),
    .seq_smpl_3 (pat[2]),
    .seq_smpl_4 (pat[3]),
    .seq_smpl_5 (pat[4]),
    .seq_smpl_6 (pat[5]),
    .seq_smpl_7 (pat[6]),
    .seq_smpl_8 (pat[7]),
    .trig       (trig_if.master),
    .overrun    (overrun),
    .step_idx   (step_idx),
    .step_tick  (step_tick),
    .running    (running)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference: 0 stopped, 1 playing, 2 paused; pos = cycles into step.
  int m_state, m_idx, m_pos, m_len;
  int m_tick, m_valid, m_mask, m_ovr;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_pos = 0; m_len = 0;
    m_tick = 0; m_valid = 0; m_mask = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit halt, begin_step, acc;
    int smp;
    halt = stop || (mode != 2'b01);
    acc = (m_valid != 0) && trig_if.trig_ready;
    begin_step = 0;
    if (halt) begin
      m_state = 0; m_idx = 0; m_pos = 0;
      m_valid = 0; m_tick = 0;
      if (stop) m_ovr = 0;
    end else begin
      if (start_stop) begin
        if (m_state == 0) begin
          m_state = 1; m_idx = 0; begin_step = 1;
        end else if (m_state == 1) begin
          m_state = 2;
        end else begin
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (m_pos + 1 == m_len) begin
          begin_step = 1;
          m_idx = (m_idx + 1) % 8;
        end else begin
          m_pos++;
        end
      end
      m_tick = begin_step;
      if (begin_step) begin
        m_pos = 0;
        m_len = (int'(tempo) + 1) * 4;
        smp = int'(pat[m_idx]);
        if (smp != 0) begin
          if (m_valid != 0 && !trig_if.trig_ready) m_ovr = 1;
          m_mask = smp;
          m_valid = 1;
        end else if (acc) begin
          m_valid = 0;
        end
      end else if (acc) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("step_idx", 8'(step_idx), 8'(m_idx));
    chk("step_tick", 8'(step_tick), 8'(m_tick));
    chk("running", 8'(running), 8'(m_state == 1));
    chk("trig_valid", 8'(trig_if.trig_valid), 8'(m_valid));
    chk("overrun", 8'(overrun), 8'(m_ovr));
    if (m_valid != 0)
      chk("trig_mask", 8'(trig_if.trig_mask), 8'(m_mask));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    rst_n = 1'b1;
    mode = 2'b01;
    start_stop = 1'b0;
    stop = 1'b0;
    tempo = 8'd1;
    trig_if.trig_ready = 1'b1;
    for (int i = 0; i < 8; i++) pat[i] = 4'd0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_all();
    chk("rst_mask", 8'(trig_if.trig_mask), 8'd0);
    #10 rst_n = 1'b1;

    // Basic walk with ready always high
    pat[0] = 4'b0001;
    pat[1] = 4'b0010;
    pat[2] = 4'b0000;
    for (int i = 3; i < 7; i++) pat[i] = 4'($urandom_range(1, 15));
    pat[7] = 4'b1000;
    pulse_ss();
    chk("t1_first_tick", 8'(step_tick), 8'd1);
    run(72);

    // Mixer stalls: second trigger replaces the first
    pulse_stop();
    pat[1] = 4'b0100;
    trig_if.trig_ready = 1'b0;
    pulse_ss();
    run(20);
    chk("t2_overrun", 8'(overrun), 8'd1);
    chk("t2_mask", 8'(trig_if.trig_mask), 8'b0100);
    pulse_stop();
    chk("t2_ovr_clr", 8'(overrun), 8'd0);
    chk("t2_valid_clr", 8'(trig_if.trig_valid), 8'd0);
    trig_if.trig_ready = 1'b1;

    // Pause at step 3, divider 5, then resume
    pulse_ss();
    n = 0;
    while (!(m_state == 1 && m_idx == 3 && m_pos == 5) && n < 100) begin
      cyc();
      n++;
    end
    chk("t3_reach", 8'(n < 100), 8'd1);
    pulse_ss();
    run(10);
    chk("t3_frozen_idx", 8'(step_idx), 8'd3);
    pulse_ss();
    chk("t3_no_resume_tick", 8'(step_tick), 8'd0);
    k = 0;
    while (!step_tick && k < 20) begin
      cyc();
      k++;
    end
    chk("t3_resume_latency", 8'(k), 8'd3);

    // Tempo change mid-step 2 applies from step 3
    while (!(m_idx == 2 && m_pos == 3) && n < 300) begin
      cyc();
      n++;
    end
    tempo = 8'd3;
    cyc();
    k = 0;
    while (!step_tick && k < 40) begin
      cyc();
      k++;
    end
    chk("t4_step3_idx", 8'(step_idx), 8'd3);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!step_tick && k < 40);
    chk("t4_step3_len", 8'(k), 8'd16);
    tempo = 8'd1;

    // Stop beats start_stop; mode loss forces stop
    start_stop = 1'b1;
    stop = 1'b1;
    cyc();
    start_stop = 1'b0;
    stop = 1'b0;
    chk("t5_idx", 8'(step_idx), 8'd0);
    chk("t5_running", 8'(running), 8'd0);
    trig_if.trig_ready = 1'b0;
    pulse_ss();
    run(11);
    mode = 2'b00;
    cyc();
    chk("t5_mode_valid", 8'(trig_if.trig_valid), 8'd0);
    chk("t5_mode_run", 8'(running), 8'd0);
    mode = 2'b01;

    // Async reset in the middle of a step with a trigger pending
    pulse_ss();
    run(5);
    chk("t6_pending", 8'(trig_if.trig_valid), 8'd1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_mask", 8'(trig_if.trig_mask), 8'd0);
    #3 rst_n = 1'b1;
    trig_if.trig_ready = 1'b1;
    pulse_ss();
    chk("t6_restart_valid", 8'(trig_if.trig_valid), 8'd1);
    chk("t6_restart_mask", 8'(trig_if.trig_mask), 8'(pat[0]));

    // Random play
    for (int i = 0; i < 800; i++) begin
      mode = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      start_stop = ($urandom_range(0, 24) == 0);
      stop = ($urandom_range(0, 89) == 0);
      tempo = 8'($urandom_range(0, 3));
      trig_if.trig_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        pat[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
